// File: rtl/store_pkg.sv
// Shared types and helpers for the store read-modify-write path.
package store_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRdAddr,
    StRdWait,
    StWrite
  } store_state_t;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Alignment and encoding check applied when a store is accepted.
  function automatic logic is_legal_store(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic legal;
    case (funct3)
      F3_SB:   legal = 1'b1;
      F3_SH:   legal = ~addr_lo[0];
      F3_SW:   legal = (addr_lo == 2'b00);
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational merge of SB/SH/SW store data into an existing memory word.
module byte_lane_merge
  import store_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] new_data,
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  output logic [WORD_W-1:0] merged_word
);

  logic [4:0] byte_lsb;
  logic [4:0] half_lsb;

  assign byte_lsb = {offset, 3'b000};
  assign half_lsb = {offset[1], 4'b0000};

  always_comb begin
    merged_word = old_word;
    case (funct3)
      F3_SB:   merged_word[byte_lsb +: 8]  = new_data[7:0];
      F3_SH:   merged_word[half_lsb +: 16] = new_data[15:0];
      F3_SW:   merged_word = new_data;
      default: merged_word = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Converts SB/SH/SW stores into full-word writes on a memory without byte enables.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [2:0]        req_funct3,
  output logic [DATA_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              done,
  output logic              err
);

  store_state_t      state_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        funct3_q;
  logic [1:0]        offset_q;
  logic [DATA_W-1:0] word_addr;
  logic [DATA_W-1:0] merged;

  assign word_addr = {req_addr[DATA_W-1:2], 2'b00};
  assign req_ready = (state_q == StIdle);

  byte_lane_merge u_merge (
    .old_word    (mem_rdata),
    .new_data    (data_q),
    .funct3      (funct3_q),
    .offset      (offset_q),
    .merged_word (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      data_q    <= '0;
      funct3_q  <= '0;
      offset_q  <= '0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (!is_legal_store(req_funct3, req_addr[1:0])) begin
              err <= 1'b1;
            end else begin
              data_q    <= req_data;
              funct3_q  <= req_funct3;
              offset_q  <= req_addr[1:0];
              mem_waddr <= word_addr;
              if (req_funct3 == F3_SW) begin
                // Full word: no read needed, raddr left untouched.
                mem_wdata <= req_data;
                mem_wr    <= 1'b1;
                state_q   <= StWrite;
              end else begin
                mem_raddr <= word_addr;
                state_q   <= StRdAddr;
              end
            end
          end
        end
        StRdAddr: state_q <= StRdWait;
        StRdWait: begin
          // Read data is valid only in this cycle.
          mem_wdata <= merged;
          mem_wr    <= 1'b1;
          state_q   <= StWrite;
        end
        StWrite: begin
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed self-checking bench for store_rmw_unit.
module tb_store_rmw_unit;

  localparam logic [31:0] Garb = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_funct3;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;

  store_rmw_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_funct3 (req_funct3),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr) wr_count <= wr_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_data   = data;
    req_funct3 = f3;
  endtask

  // SB/SH: read data is presented only in the RD_WAIT cycle, garbage elsewhere.
  task automatic run_rmw(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] f3, input logic [31:0] old,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
    int wr0;
    @(negedge clk);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    drive(addr, data, f3);
    mem_rdata = Garb;
    wr0 = wr_count;
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = 32'h5A5A_5A5A;
    check({tag, " raddr"}, mem_raddr, exp_addr);
    check({tag, " wr T+1"}, 32'(mem_wr), 32'd0);
    check({tag, " busy"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    check({tag, " wr T+2"}, 32'(mem_wr), 32'd0);
    mem_rdata = old;
    @(negedge clk);
    mem_rdata = Garb;
    check({tag, " wr T+3"}, 32'(mem_wr), 32'd1);
    check({tag, " waddr"}, mem_waddr, exp_addr);
    check({tag, " wdata"}, mem_wdata, exp_wdata);
    check({tag, " done T+3"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, " done T+4"}, 32'(done), 32'd1);
    check({tag, " err T+4"}, 32'(err), 32'd0);
    check({tag, " wr T+4"}, 32'(mem_wr), 32'd0);
    check({tag, " ready T+4"}, 32'(req_ready), 32'd1);
    check({tag, " wr count"}, 32'(wr_count - wr0), 32'd1);
  endtask

  task automatic run_sw(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_raddr);
    @(negedge clk);
    drive(addr, data, 3'b010);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, " wr T+1"}, 32'(mem_wr), 32'd1);
    check({tag, " waddr"}, mem_waddr, addr);
    check({tag, " wdata"}, mem_wdata, data);
    check({tag, " raddr kept"}, mem_raddr, exp_raddr);
    check({tag, " done T+1"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, " done T+2"}, 32'(done), 32'd1);
    check({tag, " wr T+2"}, 32'(mem_wr), 32'd0);
    check({tag, " ready T+2"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    check({tag, " done T+3"}, 32'(done), 32'd0);
  endtask

  initial begin
    int wr0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_funct3 = '0;
    mem_rdata  = Garb;
    repeat (2) @(negedge clk);
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst wr", 32'(mem_wr), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst raddr", mem_raddr, 32'd0);
    check("rst waddr", mem_waddr, 32'd0);
    check("rst wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    run_rmw("sb", 32'h0000_0102, 32'h0000_00AB, 3'b000, 32'h1122_3344,
            32'h0000_0100, 32'h11AB_3344);
    run_rmw("sh", 32'h0000_0202, 32'h0000_BEEF, 3'b001, 32'hDEAD_C0DE,
            32'h0000_0200, 32'hBEEF_C0DE);
    run_sw("sw", 32'h0000_0300, 32'hCAFE_F00D, 32'h0000_0200);

    // Illegal requests: misaligned SH, then reserved funct3.
    @(negedge clk);
    wr0 = wr_count;
    drive(32'h0000_0101, 32'h1234_5678, 3'b001);
    @(negedge clk);
    check("err sh", 32'(err), 32'd1);
    check("err sh ready", 32'(req_ready), 32'd1);
    check("err sh done", 32'(done), 32'd0);
    drive(32'h0000_0000, 32'h1234_5678, 3'b011);
    @(negedge clk);
    check("err f3", 32'(err), 32'd1);
    check("err f3 ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    check("err clear", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    check("err no wr", 32'(wr_count - wr0), 32'd0);

    // Back-to-back SBs with valid held; second accepted on the done cycle.
    @(negedge clk);
    drive(32'h0000_0100, 32'h0000_0011, 3'b000);
    mem_rdata = Garb;
    @(negedge clk);
    check("b2b1 raddr", mem_raddr, 32'h0000_0100);
    @(negedge clk);
    mem_rdata = 32'h0000_0000;
    @(negedge clk);
    mem_rdata = Garb;
    check("b2b1 wr", 32'(mem_wr), 32'd1);
    check("b2b1 wdata", mem_wdata, 32'h0000_0011);
    drive(32'h0000_0103, 32'h0000_0044, 3'b000);
    @(negedge clk);
    check("b2b1 done", 32'(done), 32'd1);
    check("b2b1 ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b2 busy", 32'(req_ready), 32'd0);
    check("b2b2 raddr", mem_raddr, 32'h0000_0100);
    check("b2b2 done low", 32'(done), 32'd0);
    @(negedge clk);
    mem_rdata = 32'h0000_0011;
    @(negedge clk);
    mem_rdata = Garb;
    check("b2b2 wr", 32'(mem_wr), 32'd1);
    check("b2b2 wdata", mem_wdata, 32'h4400_0011);
    @(negedge clk);
    check("b2b2 done", 32'(done), 32'd1);

    // Reset during RD_WAIT abandons the store.
    @(negedge clk);
    drive(32'h0000_0102, 32'h0000_00AB, 3'b000);
    mem_rdata = Garb;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    mem_rdata = 32'h1122_3344;
    wr0 = wr_count;
    rst_n = 1'b0;
    #1;
    check("mid rst wr", 32'(mem_wr), 32'd0);
    check("mid rst done", 32'(done), 32'd0);
    check("mid rst ready", 32'(req_ready), 32'd1);
    check("mid rst raddr", mem_raddr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rdata = Garb;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post rst wr", 32'(mem_wr), 32'd0);
      check("post rst done", 32'(done), 32'd0);
    end
    check("post rst no wr", 32'(wr_count - wr0), 32'd0);
    run_sw("sw post rst", 32'h0000_0304, 32'h1234_5678, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Write-side companion to the data memory's load path. Accepts one store per handshake from the MEM stage, with funct3 SB/SH/SW and a byte address. It turns each store into a word-wide write on the single-port `Memoria32Data` interface, which has no byte enables. SB/SH use a read-modify-write sequence; SW is written directly. The block sits between the pipeline's MEM stage and the memory's `raddress`/`waddress`/`Datain`/`Wr` pins.

## Interface
Parameters:
- `DATA_W`, 32, data and address width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  store request present
- `req_ready`  out  1  block can accept a request
- `req_addr`  in  DATA_W  byte address (rs1 + imm)
- `req_data`  in  DATA_W  rs2 store data
- `req_funct3`  in  3  000 SB, 001 SH, 010 SW
- `mem_raddr`  out  DATA_W  word-aligned read address to memory
- `mem_rdata`  in  DATA_W  memory read data (one-cycle latency after `mem_raddr`)
- `mem_waddr`  out  DATA_W  word-aligned write address
- `mem_wdata`  out  DATA_W  merged write word
- `mem_wr`  out  1  write strobe
- `done`  out  1  one-cycle pulse; the store has been written
- `err`  out  1  one-cycle pulse; the request was misaligned or had an illegal funct3 and was dropped

## Operation
- States: `IDLE`, `RD_ADDR`, `RD_WAIT`, `WRITE`.
- `req_ready` = (state == `IDLE`). A request is accepted on `req_valid && req_ready`. Address, data, funct3 and byte offset are latched.
- Word address = `{req_addr[31:2], 2'b00}`. It drives both `mem_raddr` and `mem_waddr`.
- Legality check at acceptance:
  - SH with `addr[0]`=1 is illegal.
  - SW with `addr[1:0]`≠0 is illegal.
  - funct3 ∉ {000, 001, 010} is illegal.
  - An illegal request produces an `err` pulse next cycle, stays in `IDLE`, and never asserts `mem_wr`.
- SW: `IDLE` → `WRITE`. `mem_wdata` = `req_data`.
- SB/SH: `IDLE` → `RD_ADDR` → `RD_WAIT` → `WRITE`.
  - `RD_ADDR` presents `mem_raddr`.
  - In `RD_WAIT`, `mem_rdata` is captured and merged.
- Merge rules:
  - SB replaces byte lane `addr[1:0]` (lane n = bits 8n+7:8n) with `req_data[7:0]`.
  - SH replaces half `addr[1]` with `req_data[15:0]`.
  - All other bits keep the old word.
- `WRITE` → `IDLE`. `done` pulses on the cycle the FSM returns to `IDLE`.
- `mem_wr` is 1 only while in `WRITE`, for exactly one cycle per legal store.

## Timing
- All outputs are registered, except `req_ready`, which is decoded from state.
- Reset values:
  - state = `IDLE`, so `req_ready` = 1.
  - `mem_wr`, `done`, `err` = 0.
  - `mem_raddr`, `mem_waddr`, `mem_wdata` = 0.
- Latency, with acceptance at edge T:
  - SW: `mem_wr` during T+1; `done` during T+2.
  - SB/SH: `mem_raddr` valid during T+1; `mem_rdata` sampled at the end of T+2; `mem_wr` during T+3; `done` during T+4.
- `req_ready` returns to 1 in the same cycle `done` is high. A back-to-back request can be accepted on that edge.
- `done` and `err` are never high in the same cycle.
- Reset asserted mid-operation clears state and all strobes immediately. A partially processed store is abandoned with no write and no `done`.
- `req_*` inputs are ignored while `req_ready` = 0; changes there have no effect on an in-flight store.

## Structure
- Package `store_pkg`:
  - state enum `store_state_t`
  - funct3 constants `F3_SB`, `F3_SH`, `F3_SW`
  - function `is_legal_store(funct3, addr_lo)`
- Sub-module `byte_lane_merge`. Purely combinational: `old_word`, `new_data`, `funct3`, `offset` → `merged_word`. It is reused later for store-to-load forwarding.

## Test plan
- SB at 0x0000_0102, data 0x0000_00AB, old word 0x1122_3344 → one `mem_wr`: addr 0x100, data 0x11AB_3344; `done` at T+4.
- SH at 0x0000_0202, data 0x0000_BEEF, old word 0xDEAD_C0DE → `mem_wdata` 0xBEEF_C0DE at T+3; no read-data sampling beyond one cycle.
- SW at 0x0000_0300, data 0xCAFE_F00D → `mem_wr` at T+1 with addr 0x300; `mem_raddr` unchanged; `done` at T+2.
- SH at 0x0000_0101, then funct3 011 at 0x0 → `err` pulse each, `mem_wr` never asserted, `req_ready` stays 1.
- Two SBs back-to-back with `req_valid` held (0x100 lane 0 = 0x11, 0x100 lane 3 = 0x44; old word 0) → second read returns 0x0000_0011; final write 0x4400_0011.
- `rst_n` low during `RD_WAIT` of an SB → no `mem_wr`, no `done`; after release `req_ready` = 1 and the next SW completes normally.
